// File: rtl/div_229x80_seq_if.sv
// Operand/result handshake bundle for the 229/80 sequential divider.
interface div_229x80_seq_if #(
  parameter int DW = 229,
  parameter int VW = 80
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_229x80_seq.sv
// Restoring divider, one quotient bit per cycle; result valid DW+1 edges after accept (1 edge for /0).
// Result is held in DONE until out_ready; no new operand is accepted until then.
module div_229x80_seq #(
  parameter int DW = 229,
  parameter int VW = 80
) (
  input  logic                 clk,
  input  logic                 rst,
  div_229x80_seq_if.slave      s_if
);
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_q;
  logic [VW-1:0] r_rem;
  logic [VW-1:0] r_div;
  logic          r_zero;
  logic          r_out_valid;
  logic [DW-1:0] r_quot_o;
  logic [VW-1:0] r_rem_o;
  logic          r_dbz;

  logic          w_accept;
  logic          w_div_zero;
  logic [VW:0]   w_trial;
  logic          w_ge;
  logic [VW-1:0] w_diff;

  assign w_accept   = s_if.in_valid && s_if.in_ready;
  assign w_div_zero = (s_if.divisor == '0);

  // The partial remainder's top bit is always zero after each step, so only
  // VW bits are stored; the trial value carries the extra bit.
  assign w_trial = {r_rem, r_q[DW-1]};
  assign w_ge    = (w_trial >= {1'b0, r_div});
  assign w_diff  = w_trial[VW-1:0] - r_div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = w_div_zero ? DONE : BUSY;
      BUSY: if (r_cnt == CW'(1)) w_next = DONE;
      DONE: if (r_out_valid && s_if.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_q         <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      r_quot_o    <= '0;
      r_rem_o     <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_div  <= s_if.divisor;
            r_zero <= w_div_zero;
            r_dbz  <= 1'b0;
            if (w_div_zero) begin
              r_q   <= '1;
              r_rem <= s_if.dividend[VW-1:0];
              r_cnt <= '0;
            end else begin
              r_q   <= s_if.dividend;
              r_rem <= '0;
              r_cnt <= CW'(DW);
            end
          end
        end
        BUSY: begin
          r_rem <= w_ge ? w_diff : w_trial[VW-1:0];
          r_q   <= {r_q[DW-2:0], w_ge};
          r_cnt <= r_cnt - CW'(1);
        end
        DONE: begin
          // First DONE cycle registers the result; later cycles only wait for out_ready.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_quot_o    <= r_q;
            r_rem_o     <= r_rem;
            r_dbz       <= r_zero;
          end else if (s_if.out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign s_if.in_ready    = (r_state == IDLE) && !rst;
  assign s_if.out_valid   = r_out_valid;
  assign s_if.quotient    = r_quot_o;
  assign s_if.remainder   = r_rem_o;
  assign s_if.div_by_zero = r_dbz;
endmodule

// File: tb/tb_div_229x80_seq.sv
// Directed-vector bench for div_229x80_seq: latency, results, /0, backpressure, reset, back-to-back.
module tb_div_229x80_seq;
  localparam int DW = 229;
  localparam int VW = 80;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_229x80_seq_if #(.DW(DW), .VW(VW)) dif ();

  div_229x80_seq #(.DW(DW), .VW(VW)) dut (
    .clk  (clk),
    .rst  (rst),
    .s_if (dif.slave)
  );

  task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b, output bit ok);
    int t;
    t  = 0;
    ok = 1'b1;
    @(negedge clk);
    while (!dif.in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!dif.in_ready) begin
      ok = 1'b0;
      return;
    end
    dif.dividend = a;
    dif.divisor  = b;
    dif.in_valid = 1'b1;
    @(posedge clk);
    #1 dif.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (lat < 400) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (dif.out_valid) break;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1 dif.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dif.in_valid = 1'b0;
    dif.out_ready = 1'b0;
    dif.dividend = '0;
    dif.divisor = '0;
    repeat (3) @(negedge clk);
    n_vec++; if (dif.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", dif.in_ready); end
    n_vec++; if (dif.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", dif.out_valid); end
    n_vec++; if (dif.quotient !== '0) begin n_err++; $display("FAIL rst_quotient: got %h want 0", dif.quotient); end
    n_vec++; if (dif.remainder !== '0) begin n_err++; $display("FAIL rst_remainder: got %h want 0", dif.remainder); end
    n_vec++; if (dif.div_by_zero !== 1'b0) begin n_err++; $display("FAIL rst_dbz: got %b want 0", dif.div_by_zero); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (dif.in_ready !== 1'b1) begin n_err++; $display("FAIL rel_in_ready: got %b want 1", dif.in_ready); end
  endtask

  task automatic test_basic();
    bit ok;
    int lat;
    issue(229'd100, 80'd7, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL basic_accept: got timeout want accept"); end
    wait_result(lat);
    n_vec++; if (lat !== 230) begin n_err++; $display("FAIL basic_latency: got %0d want 230", lat); end
    n_vec++; if (dif.quotient !== 229'd14) begin n_err++; $display("FAIL basic_q: got %h want e", dif.quotient); end
    n_vec++; if (dif.remainder !== 80'd2) begin n_err++; $display("FAIL basic_r: got %h want 2", dif.remainder); end
    n_vec++; if (dif.div_by_zero !== 1'b0) begin n_err++; $display("FAIL basic_dbz: got %b want 0", dif.div_by_zero); end
    handshake();
  endtask

  task automatic test_round_trip();
    bit ok;
    int lat;
    logic [DW-1:0] a, q_exp;
    logic [VW-1:0] b;
    a     = (229'(1) << 227) + (229'(3) << 148) + (229'(5) << 79) + 229'd15;
    b     = (80'(1) << 79) + 80'd3;
    q_exp = (229'(1) << 148) + 229'd5;
    issue(a, b, ok);
    wait_result(lat);
    n_vec++; if (dif.quotient !== q_exp) begin n_err++; $display("FAIL rt_q: got %h want %h", dif.quotient, q_exp); end
    n_vec++; if (dif.remainder !== 80'd0) begin n_err++; $display("FAIL rt_r: got %h want 0", dif.remainder); end
    handshake();
  endtask

  task automatic test_extremes();
    bit ok;
    int lat;
    logic [DW-1:0] ones_q;
    logic [VW-1:0] ones_v;
    ones_q = '1;
    ones_v = '1;
    issue(ones_q, 80'd1, ok);
    wait_result(lat);
    n_vec++; if (dif.quotient !== ones_q) begin n_err++; $display("FAIL max_q: got %h want %h", dif.quotient, ones_q); end
    n_vec++; if (dif.remainder !== 80'd0) begin n_err++; $display("FAIL max_r: got %h want 0", dif.remainder); end
    handshake();
    issue(229'd5, ones_v, ok);
    wait_result(lat);
    n_vec++; if (dif.quotient !== 229'd0) begin n_err++; $display("FAIL small_q: got %h want 0", dif.quotient); end
    n_vec++; if (dif.remainder !== 80'd5) begin n_err++; $display("FAIL small_r: got %h want 5", dif.remainder); end
    handshake();
  endtask

  task automatic test_div_zero();
    bit ok;
    int lat;
    logic [DW-1:0] a, ones_q;
    ones_q = '1;
    a = (229'(1) << 80) | 229'h0ABC;
    issue(a, 80'd0, ok);
    wait_result(lat);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL dz_latency: got %0d want 1", lat); end
    n_vec++; if (dif.quotient !== ones_q) begin n_err++; $display("FAIL dz_q: got %h want all ones", dif.quotient); end
    n_vec++; if (dif.remainder !== 80'hABC) begin n_err++; $display("FAIL dz_r: got %h want abc", dif.remainder); end
    n_vec++; if (dif.div_by_zero !== 1'b1) begin n_err++; $display("FAIL dz_flag: got %b want 1", dif.div_by_zero); end
    handshake();
    issue(229'd100, 80'd7, ok);
    n_vec++; if (dif.div_by_zero !== 1'b0) begin n_err++; $display("FAIL dz_clear_on_accept: got %b want 0", dif.div_by_zero); end
    wait_result(lat);
    n_vec++; if (dif.quotient !== 229'd14 || dif.div_by_zero !== 1'b0) begin
      n_err++; $display("FAIL dz_next_op: got q=%h dbz=%b want q=e dbz=0", dif.quotient, dif.div_by_zero);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    int highs;
    issue(229'd1000, 80'd10, ok);
    repeat (20) @(negedge clk);
    dif.dividend = 229'd9;
    dif.divisor  = 80'd2;
    dif.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    dif.in_valid = 1'b0;
    wait_result(lat);
    n_vec++; if (dif.quotient !== 229'd100 || dif.remainder !== 80'd0) begin
      n_err++; $display("FAIL bp_result: got q=%h r=%h want q=64 r=0", dif.quotient, dif.remainder);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if (dif.out_valid !== 1'b1 || dif.quotient !== 229'd100 || dif.remainder !== 80'd0 || dif.in_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold_%0d: got v=%b q=%h r=%h rdy=%b want v=1 q=64 r=0 rdy=0",
                          i, dif.out_valid, dif.quotient, dif.remainder, dif.in_ready);
      end
    end
    handshake();
    n_vec++; if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_release: got rdy=%b v=%b want rdy=1 v=0", dif.in_ready, dif.out_valid);
    end
    issue(229'd100, 80'd7, ok);
    wait_result(lat);
    n_vec++; if (dif.quotient !== 229'd14 || lat !== 230) begin
      n_err++; $display("FAIL bp_next_op: got q=%h lat=%0d want q=e lat=230", dif.quotient, lat);
    end
    handshake();
    highs = 0;
    repeat (240) begin
      @(negedge clk);
      if (dif.out_valid) highs++;
    end
    n_vec++; if (highs !== 0) begin n_err++; $display("FAIL bp_single_result: got %0d extra valid cycles want 0", highs); end
  endtask

  task automatic test_reset_midop();
    bit ok;
    int lat;
    issue(229'd100, 80'd7, ok);
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_vec++; if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b0) begin
      n_err++; $display("FAIL midrst_assert: got v=%b rdy=%b want v=0 rdy=0", dif.out_valid, dif.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0) begin
      n_err++; $display("FAIL midrst_release: got rdy=%b v=%b want rdy=1 v=0", dif.in_ready, dif.out_valid);
    end
    issue(229'd100, 80'd7, ok);
    wait_result(lat);
    n_vec++; if (lat !== 230 || dif.quotient !== 229'd14 || dif.remainder !== 80'd2) begin
      n_err++; $display("FAIL midrst_fresh: got lat=%0d q=%h r=%h want lat=230 q=e r=2", lat, dif.quotient, dif.remainder);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int lat;
    int c_a, c_b;
    issue(229'd100, 80'd7, ok);
    c_a = cyc;
    dif.out_ready = 1'b1;
    issue(229'd200, 80'd7, ok);
    c_b = cyc;
    n_vec++; if (!ok || (c_b - c_a) !== 232) begin
      n_err++; $display("FAIL b2b_interval: got %0d ok=%b want 232", c_b - c_a, ok);
    end
    wait_result(lat);
    n_vec++; if (dif.quotient !== 229'd28 || dif.remainder !== 80'd4) begin
      n_err++; $display("FAIL b2b_second: got q=%h r=%h want q=1c r=4", dif.quotient, dif.remainder);
    end
    @(posedge clk);
    #1 dif.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_trip();
    test_extremes();
    test_div_zero();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/div_229x80_seq.md
# div_229x80_seq

Sequential restoring divider that inverts the 149x80 wide multiplier path. It takes a 229-bit dividend (product width) and an 80-bit divisor and returns a 229-bit quotient and an 80-bit remainder. It produces one quotient bit per cycle. It sits downstream of the wide-multiply datapath and serves reduction and round-trip checks of products, where throughput is non-critical and DSP budget is exhausted.

## Interface
- DW, 229, dividend and quotient width
- VW, 80, divisor and remainder width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  dividend/divisor valid
- in_ready  out  1  divider can accept an operation
- dividend  in  DW  unsigned dividend
- divisor  in  VW  unsigned divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  DW  unsigned quotient
- remainder  out  VW  unsigned remainder
- div_by_zero  out  1  divisor was zero for this result

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On the accept edge (in_valid && in_ready), latch dividend into the quotient shift register and divisor into the divisor register.
  - Clear the partial remainder (VW+1 bits).
  - Load iteration counter = DW.
  - Go to BUSY, or to DONE if divisor==0.
- BUSY, each cycle:
  - Form {rem[VW-1:0], q[DW-1]} as the trial value, (VW+1) bits.
  - If trial >= divisor: rem = trial - divisor, shift 1 into q[0]. Else: rem = trial, shift 0 into q[0].
  - Decrement the counter. When it reaches 0, go to DONE.
- DONE:
  - out_valid=1; quotient, remainder and div_by_zero are held stable.
  - On the edge where out_valid && out_ready, go to IDLE.
- Divide by zero: quotient = all ones, remainder = dividend[VW-1:0], div_by_zero=1. No iterations are performed.
- in_ready=0 in BUSY and DONE. Inputs are ignored outside IDLE, so there is no overlap of operations.
- remainder < divisor is guaranteed for divisor != 0. The MSB of the partial remainder is always 0 at DONE, and remainder = rem[VW-1:0].
- div_by_zero is cleared on the next accept.

## Timing
- Reset values: in_ready=0 while rst is asserted and 1 after release. out_valid=0, quotient=0, remainder=0, div_by_zero=0. Counter=0, state=IDLE.
- Latency, divisor != 0: out_valid rises DW+1 edges after the accept edge (DW iteration edges plus the transition into DONE is folded into the last iteration, plus 1 registered output edge). Exactly 230 cycles from accept to first out_valid.
- Latency, divisor == 0: out_valid rises 1 edge after accept.
- Back-to-back operation:
  - in_ready returns to 1 the cycle after the out handshake.
  - Minimum issue interval is 232 cycles (accept, 229 iterations, DONE, handshake).
- Backpressure: out_valid stays high and outputs are unchanged for any number of cycles with out_ready=0.
- Reset mid-operation: asserting rst in any state immediately forces all outputs and state to the reset values. The in-flight operation is discarded and no result is produced.
- in_valid asserted during BUSY or DONE has no effect and is not queued.

## Test plan
- dividend=100, divisor=7 -> quotient=14, remainder=2, div_by_zero=0. out_valid rises exactly 230 cycles after accept.
- Round trip: dividend = (2^148+5)*(2^79+3), divisor = 2^79+3 -> quotient = 2^148+5, remainder=0.
- Extremes:
  - dividend = 2^229-1, divisor=1 -> quotient = 2^229-1, remainder=0.
  - dividend=5, divisor = 2^80-1 -> quotient=0, remainder=5.
- divisor=0, dividend=0x1_0000_0000_0000_0000_0ABC -> out_valid 1 cycle after accept, quotient = all ones, remainder=0xABC, div_by_zero=1. The next valid op clears div_by_zero.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0. out_ready=1 -> in_ready=1 next cycle. in_valid pulses during BUSY are ignored; the next accepted operation produces exactly one result.
- Reset mid-op: assert rst 50 cycles after accept -> out_valid=0, in_ready=1 after release. A fresh 100/7 then yields 14 r 2 with nominal latency.
